// File: rtl/key_schedule_sequencer_if.sv
// key_schedule_sequencer_if
//   Request and round-key streaming bus between a key-schedule requester/consumer (master)
//   and the key_schedule_sequencer (slave).
//   Signals:
//     req_valid/req_ready  request handshake; req_load selects expand (1) or replay (0),
//                          req_decrypt selects descending (1) or ascending (0) order
//     key_in               128-bit cipher key, byte 0 in [127:120]
//     rk_valid/rk_ready    round-key handshake; rk_out/rk_index carry the key and its round,
//                          rk_last marks the final key of a sequence
interface key_schedule_sequencer_if #(
   parameter int unsigned IDX_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic             req_load;
   logic             req_decrypt;
   logic [127:0]     key_in;
   logic [127:0]     rk_out;
   logic [IDX_W-1:0] rk_index;
   logic             rk_valid;
   logic             rk_ready;
   logic             rk_last;

   modport master (
      output req_valid, req_load, req_decrypt, key_in, rk_ready,
      input  req_ready, rk_out, rk_index, rk_valid, rk_last
   );

   modport slave (
      input  req_valid, req_load, req_decrypt, key_in, rk_ready,
      output req_ready, rk_out, rk_index, rk_valid, rk_last
   );
endinterface

// File: rtl/key_schedule_sequencer.sv
// key_schedule_sequencer
//   Iterative AES-128 key expansion: a loaded cipher key is expanded into an 11-entry
//   round-key buffer at one key per cycle, then streamed over a valid/ready port, ascending
//   for encryption or descending for decryption. A stored schedule can be replayed.
//   Ports:
//     clock        rising-edge clock
//     reset        synchronous, active-high
//     bus          key_schedule_sequencer_if.slave (request in, round keys out)
//     sched_valid  buffer holds a complete schedule
//     err          one-cycle pulse when a replay is requested without a stored schedule
module key_schedule_sequencer #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                     clock,
   input  logic                     reset,
   key_schedule_sequencer_if.slave  bus,
   output logic                     sched_valid,
   output logic                     err
);
   localparam int unsigned IDX_W = $clog2(NUM_ROUNDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

   if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("key_schedule_sequencer: only NUM_ROUNDS=10 (AES-128) is supported");
   end

   // Forward AES S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc5_3001672bfed7ab76, 128'hca82c97dfa5947f0_add4a2af9ca472c0,
      128'hb7fd9326363ff7cc_34a5e5f171d83115, 128'h04c723c31896059a_071280e2eb27b275,
      128'h09832c1a1b6e5aa0_523bd6b329e32f84, 128'h53d100ed20fcb15b_6acbbe394a4c58cf,
      128'hd0efaafb434d3385_45f9027f503c9fa8, 128'h51a3408f929d38f5_bcb6da2110fff3d2,
      128'hcd0c13ec5f974417_c4a77e3d645d1973, 128'h60814fdc222a9088_46eeb814de5e0bdb,
      128'he0323a0a4906245c_c2d3ac629195e479, 128'he7c8376d8dd54ea9_6c56f4ea657aae08,
      128'hba78252e1ca6b4c6_e8dd741f4bbd8b8a, 128'h703eb5664803f60e_613557b986c11d9e,
      128'he1f8981169d98e94_9b1e87e9ce5528df, 128'h8ca1890dbfe64268_41992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One AES-128 key-expansion step: previous round key -> next round key.
   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   typedef enum logic [1:0] {StIdle, StExpand, StEmit} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       rcon_q;
   logic             dir_q;
   logic             sched_valid_q;
   logic             err_q;
   logic [127:0]     rk_out_q;
   logic [IDX_W-1:0] rk_index_q;
   logic             rk_valid_q;
   logic             rk_last_q;
   logic [127:0]     key_buf [0:NUM_ROUNDS];

   logic             req_ready;
   logic [IDX_W-1:0] end_idx;
   logic [IDX_W-1:0] rd_next;

   assign req_ready = (state_q == StIdle) && !reset;
   assign end_idx   = dir_q ? '0 : LAST_IDX;
   assign rd_next   = dir_q ? rk_index_q - 1'b1 : rk_index_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         rcon_q        <= 8'h00;
         dir_q         <= 1'b0;
         sched_valid_q <= 1'b0;
         err_q         <= 1'b0;
         rk_out_q      <= '0;
         rk_index_q    <= '0;
         rk_valid_q    <= 1'b0;
         rk_last_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  dir_q <= bus.req_decrypt;
                  if (bus.req_load) begin
                     idx_q         <= IDX_W'(1);
                     rcon_q        <= 8'h01;
                     sched_valid_q <= 1'b0;
                     state_q       <= StExpand;
                  end else if (sched_valid_q) begin
                     rk_index_q <= bus.req_decrypt ? LAST_IDX : '0;
                     state_q    <= StEmit;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StExpand: begin
               idx_q  <= idx_q + 1'b1;
               rcon_q <= xtime(rcon_q);
               if (idx_q == LAST_IDX) begin
                  sched_valid_q <= 1'b1;
                  rk_index_q    <= dir_q ? LAST_IDX : '0;
                  state_q       <= StEmit;
               end
            end
            StEmit: begin
               // First EMIT cycle only fetches; afterwards one key per accepted handshake.
               if (!rk_valid_q) begin
                  rk_valid_q <= 1'b1;
                  rk_out_q   <= key_buf[rk_index_q];
                  rk_last_q  <= (rk_index_q == end_idx);
               end else if (bus.rk_ready) begin
                  if (rk_last_q) begin
                     rk_valid_q <= 1'b0;
                     rk_last_q  <= 1'b0;
                     state_q    <= StIdle;
                  end else begin
                     rk_index_q <= rd_next;
                     rk_out_q   <= key_buf[rd_next];
                     rk_last_q  <= (rd_next == end_idx);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Round-key buffer; contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clock) begin
      if (req_ready && bus.req_valid && bus.req_load) begin
         key_buf[0] <= bus.key_in;
      end else if (state_q == StExpand && !reset) begin
         key_buf[idx_q] <= next_key(key_buf[idx_q - 1'b1], rcon_q);
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rk_out    = rk_out_q;
   assign bus.rk_index  = rk_index_q;
   assign bus.rk_valid  = rk_valid_q;
   assign bus.rk_last   = rk_last_q;
   assign sched_valid   = sched_valid_q;
   assign err           = err_q;
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// tb_key_schedule_sequencer
//   Directed bench for key_schedule_sequencer using the FIPS-197 A.1 key schedule.
module tb_key_schedule_sequencer;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic sched_valid;
   logic err;
   int   checks   = 0;
   int   failures = 0;
   logic [127:0] exp_keys [0:10];

   key_schedule_sequencer_if #(.IDX_W(4)) bus ();

   key_schedule_sequencer #(.NUM_ROUNDS(10)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .sched_valid (sched_valid),
      .err         (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Counts clock edges (from the negedge after acceptance) until rk_valid is seen.
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.rk_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
   endtask

   // Receives one full 11-key sequence, optionally with random rk_ready stalls.
   task automatic collect(input bit dec, input bit stall, input string tag);
      int k   = 0;
      int cyc = 0;
      while (k < 11 && cyc < 300) begin
         check({tag, " valid"}, bus.rk_valid, 1'b1);
         if (bus.rk_valid) begin
            int idx = dec ? 10 - k : k;
            check({tag, " key"}, bus.rk_out, exp_keys[idx]);
            check({tag, " index"}, bus.rk_index, idx);
            check({tag, " last"}, bus.rk_last, (k == 10));
            check({tag, " busy"}, bus.req_ready, 1'b0);
            if (stall) bus.rk_ready = 1'($urandom_range(0, 1));
            else       bus.rk_ready = 1'b1;
            if (bus.rk_ready) k++;
         end
         @(negedge clock);
         cyc++;
      end
      check({tag, " count"}, k, 11);
      if (!stall) check({tag, " throughput"}, cyc, 11);
      check({tag, " done valid"}, bus.rk_valid, 1'b0);
      check({tag, " done ready"}, bus.req_ready, 1'b1);
      bus.rk_ready = 1'b1;
   endtask

   initial begin
      int n;
      exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      bus.req_valid   = 1'b0;
      bus.req_load    = 1'b0;
      bus.req_decrypt = 1'b0;
      bus.key_in      = '0;
      bus.rk_ready    = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst req_ready", bus.req_ready, 1'b0);
      check("rst rk_valid", bus.rk_valid, 1'b0);
      check("rst rk_last", bus.rk_last, 1'b0);
      check("rst sched_valid", sched_valid, 1'b0);
      check("rst err", err, 1'b0);
      check("rst rk_out", bus.rk_out, 128'h0);
      check("rst rk_index", bus.rk_index, 4'd0);
      reset = 1'b0;
      #1;
      check("idle req_ready", bus.req_ready, 1'b1);

      // Replay with no stored schedule
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_load  = 1'b0;
      @(negedge clock);
      bus.req_valid = 1'b0;
      check("err pulse", err, 1'b1);
      check("err no key", bus.rk_valid, 1'b0);
      check("err stays idle", bus.req_ready, 1'b1);
      @(negedge clock);
      check("err one cycle", err, 1'b0);
      check("err no key later", bus.rk_valid, 1'b0);

      // Load, encrypt order
      bus.rk_ready    = 1'b1;
      bus.req_valid   = 1'b1;
      bus.req_load    = 1'b1;
      bus.req_decrypt = 1'b0;
      bus.key_in      = exp_keys[0];
      @(negedge clock);
      bus.req_valid = 1'b0;
      check("expand sched_valid", sched_valid, 1'b0);
      check("expand req_ready", bus.req_ready, 1'b0);
      wait_valid(n);
      check("enc latency", n, 11);
      check("enc sched_valid", sched_valid, 1'b1);
      collect(1'b0, 1'b0, "enc");

      // Load, decrypt order
      bus.req_valid   = 1'b1;
      bus.req_decrypt = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      wait_valid(n);
      check("dec latency", n, 11);
      collect(1'b1, 1'b0, "dec");

      // Replay, encrypt order, random stalls
      bus.req_valid   = 1'b1;
      bus.req_load    = 1'b0;
      bus.req_decrypt = 1'b0;
      @(negedge clock);
      bus.req_valid = 1'b0;
      wait_valid(n);
      check("replay latency", n, 1);
      collect(1'b0, 1'b1, "enc stall");

      // Replay decrypt with stalls; a zero-key load is held pending during EMIT
      bus.req_valid   = 1'b1;
      bus.req_load    = 1'b0;
      bus.req_decrypt = 1'b1;
      @(negedge clock);
      bus.req_load = 1'b1;
      bus.key_in   = '0;
      wait_valid(n);
      check("replay dec latency", n, 1);
      collect(1'b1, 1'b1, "dec stall");
      check("pending sched_valid", sched_valid, 1'b1);
      @(negedge clock);
      bus.req_valid = 1'b0;
      check("reload invalidates", sched_valid, 1'b0);
      wait_valid(n);
      check("zero latency", n, 11);
      check("zero first index", bus.rk_index, 4'd10);
      check("zero key idx10", bus.rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      n = 0;
      while (n < 40) begin
         if (bus.rk_valid) n++;
         if (bus.rk_valid && bus.rk_last) break;
         @(negedge clock);
      end
      check("zero count", n, 11);
      check("zero last index", bus.rk_index, 4'd0);
      check("zero key idx0", bus.rk_out, 128'h0);
      @(negedge clock);

      // Reset during EXPAND at idx 5
      bus.req_valid   = 1'b1;
      bus.req_load    = 1'b1;
      bus.req_decrypt = 1'b0;
      bus.key_in      = exp_keys[0];
      @(negedge clock);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst expand rk_valid", bus.rk_valid, 1'b0);
      check("rst expand sched_valid", sched_valid, 1'b0);
      check("rst expand req_ready", bus.req_ready, 1'b1);

      // Reset during EMIT at idx 3
      @(negedge clock);
      bus.req_valid = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      wait_valid(n);
      check("emit latency", n, 11);
      n = 0;
      while (bus.rk_index != 4'd3 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("emit reached idx3", bus.rk_index, 4'd3);
      check("emit key3", bus.rk_out, exp_keys[3]);
      check("emit sched_valid", sched_valid, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst emit rk_valid", bus.rk_valid, 1'b0);
      check("rst emit sched_valid", sched_valid, 1'b0);
      check("rst emit req_ready", bus.req_ready, 1'b1);

      // Replay after mid-EMIT reset is refused
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_load  = 1'b0;
      @(negedge clock);
      bus.req_valid = 1'b0;
      check("post-rst replay err", err, 1'b1);
      check("post-rst replay no key", bus.rk_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
